// File: rtl/ipsmacge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ipsmacge_pkg
// Description : Shared types and helpers for the GE MAC variable delay line.
// Revision    : 1.0 - initial release
// ============================================================================
package ipsmacge_pkg;

    typedef enum logic {
        VD_FILL = 1'b0,
        VD_RUN  = 1'b1
    } vd_state_e;

    localparam int VD_DW   = 8;
    localparam int VD_MAXD = 16;

    // Maps a raw delay request onto the supported range 1..maxd.
    function automatic int unsigned clamp_dly(input int unsigned cfg, input int unsigned maxd);
        if (cfg == 0) begin
            return 1;
        end
        if (cfg > maxd) begin
            return maxd;
        end
        return cfg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ipsmacge_vd_ram.sv
`default_nettype none
// ============================================================================
// Module      : ipsmacge_vd_ram
// Description : Simple dual-port register array, one write and one async read.
// Revision    : 1.0 - initial release
// ============================================================================
module ipsmacge_vd_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/ipsmacge_var_delay.sv
`default_nettype none
// ============================================================================
// Module      : ipsmacge_var_delay
// Description : Runtime-programmable delay (1..MAXD) of a data word + valid.
// Revision    : 1.0 - initial release
// ============================================================================
module ipsmacge_var_delay
    import ipsmacge_pkg::*;
#(
    parameter int DW   = VD_DW,
    parameter int MAXD = VD_MAXD,
    parameter int AW   = $clog2(MAXD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW:0]   cfg_dly,
    input  logic [DW-1:0] idat,
    input  logic          ivld,
    output logic [DW-1:0] odat,
    output logic          ovld,
    output logic          filling
);

    localparam logic [AW:0]   c_dly_one  = (AW+1)'(1);
    localparam logic [AW-1:0] c_addr_one = AW'(1);

    vd_state_e     state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW:0]   dly_q, dly_d;
    logic [DW-1:0] odat_q, odat_d;
    logic          ovld_q, ovld_d;
    logic          filling_q, filling_d;

    logic [AW:0]   w_dly_eff;
    logic [AW-1:0] w_raddr;
    logic [DW:0]   w_ram_rdata;
    logic [DW:0]   w_rd_word;

    assign w_dly_eff = (AW+1)'(clamp_dly(32'(cfg_dly), 32'(MAXD)));

    // D=MAXD drops to 0 in the low bits, so the read lands on wptr+1: the oldest slot.
    assign w_raddr = wptr_q - dly_q[AW-1:0] + c_addr_one;

    ipsmacge_vd_ram #(
        .WIDTH (DW + 1),
        .DEPTH (MAXD),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (1'b1),
        .waddr_i (wptr_q),
        .wdata_i ({ivld, idat}),
        .raddr_i (w_raddr),
        .rdata_o (w_ram_rdata)
    );

    // With D=1 the read slot is the one being written this cycle.
    assign w_rd_word = (dly_q == c_dly_one) ? {ivld, idat} : w_ram_rdata;

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q + c_addr_one;
        cnt_d     = cnt_q;
        dly_d     = dly_q;
        odat_d    = '0;
        ovld_d    = 1'b0;
        filling_d = 1'b1;

        if (w_dly_eff != dly_q) begin
            dly_d   = w_dly_eff;
            cnt_d   = '0;
            state_d = VD_FILL;
        end else begin
            case (state_q)
                VD_FILL: begin
                    cnt_d = cnt_q + c_addr_one;
                    if ({1'b0, cnt_q} == dly_q - c_dly_one) begin
                        state_d = VD_RUN;
                    end
                end
                VD_RUN: begin
                    state_d = VD_RUN;
                end
                default: begin
                    state_d = VD_FILL;
                end
            endcase
        end

        // Outputs follow the state being entered so the first word lands exactly D cycles in.
        if (state_d == VD_RUN) begin
            {ovld_d, odat_d} = w_rd_word;
            filling_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= VD_FILL;
            wptr_q    <= '0;
            cnt_q     <= '0;
            dly_q     <= w_dly_eff;
            odat_q    <= '0;
            ovld_q    <= 1'b0;
            filling_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            cnt_q     <= cnt_d;
            dly_q     <= dly_d;
            odat_q    <= odat_d;
            ovld_q    <= ovld_d;
            filling_q <= filling_d;
        end
    end

    assign odat    = odat_q;
    assign ovld    = ovld_q;
    assign filling = filling_q;

endmodule
`default_nettype wire

// File: tb/tb_ipsmacge_var_delay.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipsmacge_var_delay
// Description : Self-checking bench for ipsmacge_var_delay against a history model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ipsmacge_var_delay;

    localparam int DW   = 8;
    localparam int MAXD = 16;
    localparam int AW   = 4;
    localparam int HMAX = 8192;

    logic          clk;
    logic          rst;
    logic [AW:0]   cfg_dly;
    logic [DW-1:0] idat;
    logic          ivld;
    logic [DW-1:0] odat;
    logic          ovld;
    logic          filling;

    ipsmacge_var_delay #(
        .DW   (DW),
        .MAXD (MAXD),
        .AW   (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_dly (cfg_dly),
        .idat    (idat),
        .ivld    (ivld),
        .odat    (odat),
        .ovld    (ovld),
        .filling (filling)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: every input word ever presented, plus the start cycle and delay of the current epoch.
    logic [DW:0] hist [HMAX];
    bit          m_valid = 1'b0;
    int          m_s     = 0;
    int          m_d     = 1;
    int          rcfg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, D=%0d)", tag, got, exp, cyc, m_d);
        end
    endtask

    function automatic int eff_dly(input int cfg);
        if (cfg < 1) return 1;
        if (cfg > MAXD) return MAXD;
        return cfg;
    endfunction

    task automatic step(input bit r, input int cfg, input bit v, input logic [DW-1:0] d);
        int          age;
        int          dn;
        logic [DW:0] exp_w;
        @(negedge clk);
        if (m_valid) begin
            age   = cyc - m_s;
            exp_w = (age >= m_d) ? hist[cyc - m_d] : '0;
            check("ovld",    32'(ovld),    32'(exp_w[DW]));
            check("odat",    32'(odat),    32'(exp_w[DW-1:0]));
            check("filling", 32'(filling), 32'(age < m_d));
        end
        rst       = r;
        cfg_dly   = cfg[AW:0];
        ivld      = v;
        idat      = d;
        hist[cyc] = {v, d};
        @(posedge clk);
        dn = eff_dly(cfg);
        if (r) begin
            m_valid = 1'b1;
            m_s     = cyc + 1;
            m_d     = dn;
        end else if (m_valid && dn != m_d) begin
            m_s = cyc + 1;
            m_d = dn;
        end
        cyc++;
    endtask

    initial begin
        bit [5:0] pat;
        pat     = 6'b011001;
        rst     = 1'b1;
        cfg_dly = '0;
        idat    = '0;
        ivld    = 1'b0;

        // Reset then a ramp at D=4.
        step(1'b1, 4, 1'b0, 8'h00);
        step(1'b1, 4, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) step(1'b0, 4, 1'b1, 8'(i + 1));

        // D=1 bypass path, then the full depth with pointer wrap.
        for (int i = 0; i < 8; i++) step(1'b0, 1, 1'b1, (i == 3) ? 8'hA5 : 8'($urandom));
        for (int i = 0; i < 40; i++) step(1'b0, 16, 1'($urandom_range(1)), 8'($urandom));

        // Clamp: 0 behaves as 1, 20 behaves as 16.
        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 8'($urandom));
        for (int i = 0; i < 24; i++) step(1'b0, 1, 1'b1, 8'($urandom));
        for (int i = 0; i < 40; i++) step(1'b0, 20, 1'b1, 8'($urandom));
        for (int i = 0; i < 20; i++) step(1'b0, 16, 1'b1, 8'($urandom));

        // Shrink the delay while running.
        for (int i = 0; i < 20; i++) step(1'b0, 5, 1'b1, 8'($urandom));
        for (int i = 0; i < 10; i++) step(1'b0, 3, 1'b1, 8'($urandom));

        // Sparse valid pattern at D=7.
        for (int i = 0; i < 24; i++) step(1'b0, 7, pat[i % 6], 8'($urandom));
        for (int i = 0; i < 10; i++) step(1'b0, 7, 1'b1, 8'($urandom));

        // One-cycle reset in the middle of a run.
        step(1'b1, 7, 1'b1, 8'h3C);
        for (int i = 0; i < 15; i++) step(1'b0, 7, 1'b1, 8'($urandom));

        // Change during fill restarts it.
        step(1'b0, 9, 1'b1, 8'h11);
        step(1'b0, 9, 1'b1, 8'h12);
        for (int i = 0; i < 15; i++) step(1'b0, 2, 1'b1, 8'($urandom));

        // Randomised soak with occasional delay changes and resets.
        rcfg = 6;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(47) == 0) rcfg = int'($urandom_range(31));
            step(($urandom_range(249) == 0), rcfg, 1'($urandom_range(1)), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
